// File: rtl/input_conditioner.sv
// Per-channel input conditioner: synchroniser chain, optional debounce filter,
// registered rise/fall strobes, sticky per-channel event flags and combined irq.
// Optional feature macro: INPUT_CONDITIONER_DEBOUNCE_EN (debounce filter).
module input_conditioner #(
    parameter int unsigned CHANNELS      = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE_BITS = 4,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] events,
    input  logic [CHANNELS-1:0] event_clear,
    output logic                irq
);

    localparam logic [CHANNELS-1:0] RESET_WORD = {CHANNELS{RESET_LEVEL}};

    // Elaboration-time parameter sanity checks.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("input_conditioner: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_BITS < 1) begin : g_bad_debounce_bits
        $error("input_conditioner: DEBOUNCE_BITS must be at least 1");
    end

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;
    logic [CHANNELS-1:0] events_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; stage 0 samples the raw asynchronous pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_WORD;
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;

    logic [DEBOUNCE_BITS-1:0] cnt_q [CHANNELS];
    logic [DEBOUNCE_BITS-1:0] cnt_d [CHANNELS];

    // Debounce: commit the synced value only after it has differed from the
    // current level for 2**DEBOUNCE_BITS consecutive cycles.
    always_comb begin
        level_d = level;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_s[i] == level[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_MAX) begin
                level_d[i] = sync_s[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DEBOUNCE_BITS'(1);
            end
        end
    end

    // Debounce counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    // No filter: the level follows the synchroniser output one edge later.
    always_comb begin
        level_d = sync_s;
    end
`endif

    // Strobes, sticky events (set wins over clear) and irq from next-state.
    always_comb begin
        rise_d   = level_d & ~level;
        fall_d   = ~level_d & level;
        events_d = (events & ~event_clear) | rise | fall;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            level  <= RESET_WORD;
            rise   <= '0;
            fall   <= '0;
            events <= '0;
            irq    <= 1'b0;
        end else begin
            level  <= level_d;
            rise   <= rise_d;
            fall   <= fall_d;
            events <= events_d;
            irq    <= |events_d;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model of the conditioning rules.
module tb_input_conditioner;

    localparam int unsigned CH = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 4;
    localparam logic        RL = 1'b0;
    localparam logic [CH-1:0] RLV = {CH{RL}};

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int LAT = SS + (1 << DB);
    localparam bit DB_ON = 1'b1;
`else
    localparam int LAT = SS + 1;
    localparam bit DB_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] in_r;
    logic [CH-1:0] clr;
    logic [CH-1:0] level, rise, fall, events;
    logic          irq;

    int checks = 0;
    int errors = 0;

    input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_BITS(DB), .RESET_LEVEL(RL)
    ) dut (
        .clk(clk), .reset(reset), .in(in_r), .level(level), .rise(rise),
        .fall(fall), .events(events), .event_clear(clr), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: inputs delayed by a queue of SS samples, then level
    // follows the delayed input (immediately, or after a run of 2**DB cycles).
    logic [CH-1:0] m_level, m_rise, m_fall, m_events;
    logic          m_irq;
    logic [CH-1:0] m_pipe [$];
    int            m_run [CH];

    always @(posedge clk) begin
        logic [CH-1:0] s, nl, ne;
        if (reset) begin
            m_pipe = {};
            for (int k = 0; k < SS; k++) m_pipe.push_back(RLV);
            m_level = RLV; m_rise = '0; m_fall = '0; m_events = '0; m_irq = 1'b0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(in_r);
            ne = (m_events & ~clr) | m_rise | m_fall;
            nl = m_level;
            if (DB_ON) begin
                for (int c = 0; c < CH; c++) begin
                    if (s[c] != m_level[c]) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == (1 << DB)) begin
                            nl[c] = s[c];
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end else begin
                nl = s;
            end
            m_rise = nl & ~m_level;
            m_fall = ~nl & m_level;
            m_level = nl;
            m_events = ne;
            m_irq = |ne;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: let the edge happen, then compare every output on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("level", 32'(level), 32'(m_level));
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
        check("events", 32'(events), 32'(m_events));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Count edges until (level & mask) == val, bounded; compare with expected latency.
    task automatic wait_level(input string tag, input logic [CH-1:0] mask,
                              input logic [CH-1:0] val, input int exp_edges);
        int k;
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if ((level & mask) == val) begin
                k = i;
                break;
            end
        end
        check(tag, 32'(k), 32'(exp_edges));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        ticks(n);
        reset = 1'b0;
    endtask

    initial begin
        int strobes;
        int ntog;
        bit found;

        // Reset with all inputs high; strobes appear only after the sync/filter latency.
        reset = 1'b1; in_r = 8'hFF; clr = '0;
        ticks(3);
        check("reset_level", 32'(level), 32'(RLV));
        check("reset_events", 32'(events), 32'h0);
        reset = 1'b0;
        wait_level("release_latency", 8'hFF, 8'hFF, LAT);
        check("release_rise", 32'(rise), 32'hFF);
        tick();
        check("release_irq", 32'(irq), 32'h1);

        // Short pulse on ch0 (15 cycles): filtered out with debounce, two strobes without.
        in_r = '0; clr = 8'hFF;
        ticks(LAT + 4);
        clr = '0;
        strobes = 0;
        in_r[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin tick(); strobes += int'(rise[0]) + int'(fall[0]); end
        in_r[0] = 1'b0;
        for (int i = 0; i < 25; i++) begin tick(); strobes += int'(rise[0]) + int'(fall[0]); end
        check("short_pulse_strobes", 32'(strobes), DB_ON ? 32'd0 : 32'd2);

        // Chatter: ch0 toggles every 3 cycles.
        strobes = 0; ntog = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0 && c % 3 == 0) begin in_r[0] = ~in_r[0]; ntog++; end
            tick();
            strobes += int'(rise[0]) + int'(fall[0]);
        end
        for (int i = 0; i < SS + 3; i++) begin tick(); strobes += int'(rise[0]) + int'(fall[0]); end
        check("chatter_strobes", 32'(strobes), DB_ON ? 32'd0 : 32'(ntog));

        // Simultaneous ch1 rise and ch2 fall.
        in_r = 8'h04;
        ticks(LAT + 4);
        clr = 8'hFF; tick(); clr = '0;
        in_r = 8'h02;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = (m_rise != 0);
        end
        check("simul_found", 32'(found), 32'h1);
        check("simul_rise", 32'(rise), 32'h02);
        check("simul_fall", 32'(fall), 32'h04);
        tick();
        check("simul_events", 32'(events), 32'h06);

        // Sticky clear: clear arriving together with a new fall strobe loses.
        in_r = 8'h08;
        ticks(LAT + 4);
        clr = 8'hFF; tick(); clr = '0;
        in_r = 8'h00;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = m_fall[3];
        end
        check("sticky_fall_seen", 32'(fall[3]), 32'h1);
        clr = 8'h08;
        tick();
        check("sticky_set_wins", 32'(events[3]), 32'h1);
        clr = 8'hFF;
        tick();
        clr = '0;
        check("sticky_cleared", 32'(events), 32'h0);
        check("sticky_irq", 32'(irq), 32'h0);

        // Reset in the middle of a debounce run restarts the full latency.
        in_r[0] = 1'b1;
        ticks(SS + 8);
        do_reset(1);
        check("midreset_level", 32'(level[0]), 32'h0);
        wait_level("midreset_latency", 8'h01, 8'h01, LAT);
        check("midreset_rise", 32'(rise[0]), 32'h1);

        // Randomized phase: slowly flipping inputs, random clears, rare resets.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 19) == 0) in_r[c] = ~in_r[c];
            end
            clr = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
